// File: rtl/sd_block_arbiter_pkg.sv
// Shared types and constants for the SD block arbiter.
package sd_arb_pkg;

  localparam int NREQ  = 3;
  localparam int LBA_W = 32;
  localparam int WD_W  = 24;

  // Requester indices
  localparam logic [1:0] FDD1 = 2'd0;
  localparam logic [1:0] HDD  = 2'd1;
  localparam logic [1:0] FDD2 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_DONE
  } arb_state_e;

  // Next requester index in round-robin order, wrapping 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    case (idx)
      FDD1:    return HDD;
      HDD:     return FDD2;
      default: return FDD1;
    endcase
  endfunction

endpackage

// File: rtl/sd_block_arbiter_if.sv
// Host-side block request / sector buffer bus shared by all requesters.
interface sd_block_arbiter_if;
  import sd_arb_pkg::*;

  logic             host_rd;
  logic             host_wr;
  logic [LBA_W-1:0] host_lba;
  logic             host_ack;
  logic [8:0]       host_buff_addr;
  logic             host_buff_wr;
  logic [7:0]       host_buff_din;

  // Arbiter side: issues the block request and supplies write data.
  modport master (
    output host_rd, host_wr, host_lba, host_buff_din,
    input  host_ack, host_buff_wr
  );

  // Host side: acknowledges and drives the sector buffer address/strobe.
  modport slave (
    input  host_rd, host_wr, host_lba, host_buff_din,
    output host_ack, host_buff_addr, host_buff_wr
  );

endinterface

// File: rtl/sd_block_arbiter_rr_pick3.sv
// Combinational round-robin picker over three requesters.
module rr_pick3
  import sd_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last_grant,
  output logic            valid,
  output logic [1:0]      idx
);

  logic [1:0] c0, c1, c2;

  // Search starts one past the last grant so nobody is served twice while another waits.
  always_comb begin
    c0    = rr_next(last_grant);
    c1    = rr_next(c0);
    c2    = rr_next(c1);
    valid = |req;
    if (req[c0])      idx = c0;
    else if (req[c1]) idx = c1;
    else              idx = c2;
  end

endmodule

// File: rtl/sd_block_arbiter.sv
// Arbitrates three block-device requesters onto a single host block interface.
module sd_block_arbiter
  import sd_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 14318180
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_rd,
  input  logic [NREQ-1:0]            req_wr,
  input  logic [NREQ-1:0][LBA_W-1:0] req_lba,
  input  logic [NREQ-1:0][7:0]       req_buff_din,
  output logic [NREQ-1:0]            req_ack,
  output logic [NREQ-1:0]            req_buff_wr,
  output logic [NREQ-1:0]            req_err,
  output logic [1:0]                 grant,
  output logic                       busy,
  sd_block_arbiter_if.master         host
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [LBA_W-1:0] host_lba_q, host_lba_d;
  logic             host_rd_q, host_rd_d;
  logic             host_wr_q, host_wr_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic             ack_prev_q, ack_prev_d;

  logic             ack_rise;
  logic             sel_req;
  logic             pick_valid;
  logic [1:0]       pick_idx;

  rr_pick3 u_pick (
    .req        (req_rd | req_wr),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // Next-state and registered-output computation for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    host_lba_d   = host_lba_q;
    host_rd_d    = host_rd_q;
    host_wr_d    = host_wr_q;
    wd_d         = wd_q;
    err_d        = '0;
    ack_prev_d   = host.host_ack;
    ack_rise     = host.host_ack & ~ack_prev_q;
    sel_req      = req_rd[grant_q] | req_wr[grant_q];
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_ISSUE;
          grant_d    = pick_idx;
          host_lba_d = req_lba[pick_idx];
          // A read wins over a simultaneous write; the write stays pending.
          host_rd_d  = req_rd[pick_idx];
          host_wr_d  = req_wr[pick_idx] & ~req_rd[pick_idx];
          wd_d       = '0;
        end
      end
      ST_ISSUE: begin
        wd_d = wd_q + WD_W'(1);
        if (ack_rise) begin
          host_rd_d = 1'b0;
          host_wr_d = 1'b0;
          state_d   = ST_XFER;
        end else if (!sel_req) begin
          // Requester withdrew before the host answered: quiet abort.
          host_rd_d = 1'b0;
          host_wr_d = 1'b0;
          state_d   = ST_DONE;
        end else if (wd_q == WD_LAST) begin
          host_rd_d = 1'b0;
          host_wr_d = 1'b0;
          err_d     = NREQ'(1) << grant_q;
          state_d   = ST_DONE;
        end
      end
      ST_XFER: begin
        if (!host.host_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= FDD1;
      last_grant_q <= FDD2;
      host_lba_q   <= '0;
      host_rd_q    <= 1'b0;
      host_wr_q    <= 1'b0;
      wd_q         <= '0;
      err_q        <= '0;
      ack_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      host_lba_q   <= host_lba_d;
      host_rd_q    <= host_rd_d;
      host_wr_q    <= host_wr_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      ack_prev_q   <= ack_prev_d;
    end
  end

  // Zero-latency routing of host ack, buffer strobe and write data to the granted requester.
  always_comb begin
    req_ack            = '0;
    req_buff_wr        = '0;
    host.host_buff_din = req_buff_din[grant_q];
    if (state_q == ST_ISSUE || state_q == ST_XFER) req_ack[grant_q] = host.host_ack;
    if (state_q == ST_XFER) req_buff_wr[grant_q] = host.host_buff_wr;
  end

  assign host.host_rd  = host_rd_q;
  assign host.host_wr  = host_wr_q;
  assign host.host_lba = host_lba_q;
  assign req_err       = err_q;
  assign grant         = grant_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Randomized self-checking bench for sd_block_arbiter with a transaction-level model.
module tb_sd_block_arbiter;
  import sd_arb_pkg::*;

  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       req_rd, req_wr;
  logic [2:0][31:0] req_lba;
  logic [2:0][7:0]  req_buff_din;
  logic [2:0]       req_ack, req_buff_wr, req_err;
  logic [1:0]       grant;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;
  int m_last = 2;

  sd_block_arbiter_if hif ();

  sd_block_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_lba      (req_lba),
    .req_buff_din (req_buff_din),
    .req_ack      (req_ack),
    .req_buff_wr  (req_buff_wr),
    .req_err      (req_err),
    .grant        (grant),
    .busy         (busy),
    .host         (hif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Round-robin rule: first requester after the last grant, cyclically.
  function automatic int rr_model(input int last, input logic [2:0] req);
    for (int k = 1; k <= 3; k++)
      if (req[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  task automatic add_req(input int j);
    int k;
    req_lba[j] = $urandom;
    k = $urandom_range(0, 2);
    req_rd[j] = (k != 1);
    req_wr[j] = (k != 0);
  endtask

  // scen: 0 normal transfer, 1 watchdog timeout, 2 requester abort
  task automatic run_txn(input int scen, input int beats, input bit allow_add, output int g);
    bit   found;
    logic rd_served;
    int   d, nb;
    found = 0;
    g = -1;
    for (int t = 0; t < 8; t++) begin
      if (hif.host_rd | hif.host_wr) begin
        found = 1;
        break;
      end
      tick();
    end
    if (!found) begin
      chk("issue_seen", 0, 1);
      return;
    end
    g = rr_model(m_last, req_rd | req_wr);
    if (g < 0) begin
      chk("model_pending", 0, 1);
      return;
    end
    rd_served = req_rd[g];
    chk("grant", grant, g);
    chk("busy_issue", busy, 1);
    chk("host_lba", hif.host_lba, req_lba[g]);
    chk("host_rd", hif.host_rd, req_rd[g]);
    chk("host_wr", hif.host_wr, req_wr[g] & ~req_rd[g]);
    if (scen == 0) begin
      d = $urandom_range(0, 8);
      repeat (d) tick();
      chk("req_held", hif.host_rd | hif.host_wr, 1);
      hif.host_ack = 1'b1;
      #1;
      chk("ack_issue", req_ack, 1 << g);
      tick();
      chk("host_drop", {hif.host_rd, hif.host_wr}, 0);
      chk("ack_xfer", req_ack, 1 << g);
      if (rd_served) req_rd[g] = 1'b0;
      else req_wr[g] = 1'b0;
      if (allow_add)
        for (int j = 0; j < 3; j++)
          if (!(req_rd[j] | req_wr[j]) && $urandom_range(0, 2) == 0) add_req(j);
      nb = (beats > 0) ? beats : $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        req_buff_din       = 24'($urandom);
        hif.host_buff_addr = 9'(b);
        hif.host_buff_wr   = 1'b1;
        #1;
        chk("buff_wr", req_buff_wr, 1 << g);
        chk("buff_din", hif.host_buff_din, req_buff_din[g]);
        tick();
        hif.host_buff_wr = 1'b0;
        #1;
        chk("buff_wr_low", req_buff_wr, 0);
        tick();
      end
      hif.host_ack = 1'b0;
      #1;
      chk("ack_fall", req_ack, 0);
      tick();
      chk("busy_done", busy, 1);
      hif.host_ack     = 1'b1;
      hif.host_buff_wr = 1'b1;
      #1;
      chk("done_ignored", {req_ack, req_buff_wr}, 0);
      tick();
      hif.host_ack     = 1'b0;
      hif.host_buff_wr = 1'b0;
      chk("busy_idle", busy, 0);
    end else if (scen == 1) begin
      for (int i = 1; i < TO; i++) begin
        tick();
        chk("to_hold", hif.host_rd | hif.host_wr, 1);
      end
      tick();
      chk("to_drop", {hif.host_rd, hif.host_wr}, 0);
      chk("to_err", req_err, 1 << g);
      chk("to_busy", busy, 1);
      req_rd[g] = 1'b0;
      req_wr[g] = 1'b0;
      tick();
      chk("to_err_clr", req_err, 0);
      chk("to_idle", busy, 0);
    end else begin
      d = $urandom_range(0, 5);
      repeat (d) tick();
      req_rd[g] = 1'b0;
      req_wr[g] = 1'b0;
      tick();
      chk("ab_drop", {hif.host_rd, hif.host_wr}, 0);
      chk("ab_no_err", req_err, 0);
      chk("ab_busy", busy, 1);
      tick();
      chk("ab_idle", busy, 0);
    end
    m_last = g;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    int scen;
    reset_n            = 1'b0;
    req_rd             = '0;
    req_wr             = '0;
    req_lba            = '0;
    req_buff_din       = '0;
    hif.host_ack       = 1'b1;
    hif.host_buff_wr   = 1'b1;
    hif.host_buff_addr = '0;
    repeat (3) tick();
    chk("rst_host_rd", hif.host_rd, 0);
    chk("rst_host_wr", hif.host_wr, 0);
    chk("rst_lba", hif.host_lba, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", req_err, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_buff_wr", req_buff_wr, 0);
    hif.host_ack     = 1'b0;
    hif.host_buff_wr = 1'b0;
    reset_n          = 1'b1;
    tick();

    // All three request at once right after reset: grants 0,1,2.
    req_lba = {32'h3000_0002, 32'h2000_0001, 32'h1000_0000};
    req_rd  = 3'b111;
    for (int k = 0; k < 3; k++) begin
      run_txn(0, 0, 1'b0, g);
      chk("rr_order", g, k);
    end

    // Single HDD read.
    req_lba[1] = 32'h0000_0123;
    req_rd[1]  = 1'b1;
    run_txn(0, 0, 1'b0, g);
    chk("hdd_grant", g, 1);

    // 512-byte read on floppy2.
    req_lba[2] = $urandom;
    req_rd[2]  = 1'b1;
    run_txn(0, 512, 1'b0, g);

    // Write from floppy1.
    req_lba[0] = $urandom;
    req_wr[0]  = 1'b1;
    run_txn(0, 0, 1'b0, g);

    // Watchdog timeout and quiet abort.
    add_req(1);
    run_txn(1, 0, 1'b0, g);
    add_req(2);
    run_txn(2, 0, 1'b0, g);

    // Reset during XFER with host_ack held high.
    req_lba[1] = $urandom;
    req_rd[1]  = 1'b1;
    tick();
    chk("rx_issue", hif.host_rd, 1);
    hif.host_ack = 1'b1;
    tick();
    reset_n = 1'b0;
    tick();
    chk("rx_busy", busy, 0);
    chk("rx_host_rd", hif.host_rd, 0);
    chk("rx_grant", grant, 0);
    chk("rx_lba", hif.host_lba, 0);
    chk("rx_ack", req_ack, 0);
    chk("rx_err", req_err, 0);
    reset_n      = 1'b1;
    req_rd       = '0;
    hif.host_ack = 1'b0;
    m_last       = 2;
    tick();

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      if ((req_rd | req_wr) == 3'b000) begin
        for (int j = 0; j < 3; j++)
          if ($urandom_range(0, 1) == 1) add_req(j);
        if ((req_rd | req_wr) == 3'b000) add_req($urandom_range(0, 2));
      end
      scen = $urandom_range(0, 9);
      scen = (scen < 7) ? 0 : (scen < 8) ? 1 : 2;
      run_txn(scen, 0, 1'b1, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_block_arbiter.md
SD_BLOCK_ARBITER -- requirements
Module: sd_block_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 14318180, sets the ISSUE-state watchdog limit in clk cycles (1 s at 14.318 MHz).
REQ-002 clk  in  1  core clock (14.318 MHz pixel clock domain); all logic on its rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 req_rd  in  3  per-requester block read request (0=floppy1, 1=HDD, 2=floppy2), level, held until its ack rises.
REQ-005 req_wr  in  3  per-requester block write request, same rules as req_rd.
REQ-006 req_lba  in  3x32  per-requester sector LBA, stable while request held.
REQ-007 req_buff_din  in  3x8  per-requester write-data byte for the current host_buff_addr.
REQ-008 req_ack  out  3  per-requester ack, host_ack routed to the granted requester only.
REQ-009 req_buff_wr  out  3  per-requester buffer write strobe.
REQ-010 req_err  out  3  one-cycle pulse: granted request timed out.
REQ-011 host_rd, host_wr  out  1 each  single shared host block request.
REQ-012 host_lba  out  32  LBA of granted request.
REQ-013 host_ack  in  1  host ack, high for the whole transfer.
REQ-014 host_buff_addr  in  9  host byte address within 512-byte sector (passed straight to requesters externally).
REQ-015 host_buff_wr  in  1  host write strobe for read data.
REQ-016 host_buff_din  out  8  write data to host, muxed from the granted requester.
REQ-017 grant  out  2  index of current/last granted requester; busy  out  1  high in any state except IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, XFER, DONE; reset state IDLE.
REQ-019 IDLE: if any req_rd|req_wr set, choose by round-robin starting at (last_grant+1) mod 3, latch grant and req_lba into host_lba, go ISSUE next cycle; else stay.
REQ-020 Request arising in the same cycle as another's: round-robin order decides; no requester granted twice while another waits.
REQ-021 ISSUE: host_rd=req_rd[grant], host_wr=req_wr[grant] registered; if both set, host_rd only, write serviced in a later grant.
REQ-022 ISSUE: on host_ack rising (0 in previous cycle, 1 now) drop host_rd/host_wr next cycle, go XFER.
REQ-023 XFER: on host_ack falling go DONE; DONE lasts exactly one cycle, updates last_grant, then IDLE.
REQ-024 req_ack[i] = host_ack AND grant==i AND state in {ISSUE,XFER}, combinational, zero latency; other bits 0.
REQ-025 req_buff_wr[i] = host_buff_wr AND grant==i AND state==XFER, combinational.
REQ-026 host_buff_din = req_buff_din[grant], combinational.
REQ-027 Watchdog: 24-bit counter cleared on entering ISSUE, increments each ISSUE cycle; at TIMEOUT_CYCLES-1 without ack: drop host_rd/host_wr, pulse req_err[grant] one cycle, go DONE.
REQ-028 Requester deasserting its request during ISSUE before ack: abort, drop host_rd/wr, go DONE, no req_err.
REQ-029 host_ack high while IDLE or DONE: ignored, no req_ack, no req_buff_wr.
REQ-030 Counters and grant pointer wrap: last_grant 2 -> 0.

Reset
REQ-031 On reset_n=0 at a clk edge: state IDLE, host_rd=0, host_wr=0, host_lba=0, grant=0, last_grant=2, watchdog=0, req_err=0, busy=0.
REQ-032 Reset mid-transfer drops host_rd/wr next edge; host_ack still high afterwards is ignored per REQ-029.

Structure
REQ-033 Package sd_arb_pkg holds state enum, NREQ=3, requester index constants (FDD1=0, HDD=1, FDD2=2), LBA width 32.
REQ-034 One sub-module rr_pick3: combinational round-robin picker (request vector, last_grant -> valid, index).

Verification
REQ-035 Single read: req_rd[1]=1, lba=0x00000123 -> ISSUE, host_rd=1, host_lba=0x123; ack rises -> host_rd=0 next cycle, req_ack=3'b010; ack falls -> DONE 1 cycle, IDLE.
REQ-036 Simultaneous req_rd=3'b111 after reset -> grant order 0,1,2, then repeat 0 only if re-requested.
REQ-037 Read data: in XFER host_buff_wr pulses 512 times on grant 2 -> req_buff_wr=3'b100 each, 3'b000 otherwise.
REQ-038 Write: req_wr[0]=1, req_buff_din[0]=0xA5 -> host_wr=1, host_buff_din=0xA5 through XFER.
REQ-039 Timeout: TIMEOUT_CYCLES=16, no host_ack -> host_rd drops after 16 ISSUE cycles, req_err[grant] one-cycle pulse, back to IDLE.
REQ-040 reset_n=0 during XFER with host_ack=1 -> next edge IDLE, all outputs at reset values, no req_ack.
